hd44780_nybble_reader: RTL and testbench

HD44780_NYBBLE_READER -- requirements
Module: hd44780_nybble_reader

---
 rtl/hd44780_nybble_reader.sv | 196 +++++++++++++++++++
 tb/tb_hd44780_nybble_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_nybble_reader.sv
// Purpose  : reads one byte from an HD44780 LCD over its 4-bit bus as two timed E pulses (high nybble, then low).
// Latency  : end_strobe arrives 2*(TAS+TCYCE)+1 clocks after the edge that accepts start_strobe (103 with defaults).
// Backpres.: none; start_strobe is honoured only in IDLE and dropped otherwise, so callers should wait for !busy.
//
// Ports:
//   CLK_I, RST_I           system clock, synchronous active-high reset
//   start_strobe, rs_in    one-cycle read request and the RS value to use for it
//   lcd_data_in[3:0]       DB7..DB4 as seen on the pads
//   lcd_rs/lcd_rw/lcd_e    LCD control pins (registered)
//   lcd_data_oe            1 = FPGA drives DB7..DB4; released for the whole read
//   DAT_O[7:0]             last byte read, held between reads
//   busy, end_strobe       read in progress; one-cycle "DAT_O valid" pulse

module hd44780_nybble_reader #(
    parameter int H4NR_TICKS_TAS   = 3,
    parameter int H4NR_TICKS_PWEH  = 22,
    parameter int H4NR_TICKS_TCYCE = 48,
    parameter int H4NR_COUNT_BITS  = 6
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       start_strobe,
    input  logic       rs_in,
    input  logic [3:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       lcd_data_oe,
    output logic [7:0] DAT_O,
    output logic       busy,
    output logic       end_strobe
);

    localparam int CB = H4NR_COUNT_BITS;

    // Illegal timing sets stop elaboration rather than producing a counter
    // that silently wraps.
    if (H4NR_TICKS_TAS < 1 || H4NR_TICKS_PWEH < 1 ||
        H4NR_TICKS_TCYCE <= H4NR_TICKS_PWEH ||
        H4NR_TICKS_TCYCE >= (1 << H4NR_COUNT_BITS) ||
        H4NR_TICKS_TAS >= (1 << H4NR_COUNT_BITS)) begin : g_cfg_err
        $error("hd44780_nybble_reader: illegal timing parameters");
    end

    // The counter is loaded with (duration - 1) on state entry and the state
    // is left on the clock where it reads zero, so each phase lasts exactly
    // its duration in clocks.
    localparam logic [CB-1:0] LD_TAS  = CB'(H4NR_TICKS_TAS - 1);
    localparam logic [CB-1:0] LD_PWEH = CB'(H4NR_TICKS_PWEH - 1);
    localparam logic [CB-1:0] LD_ELOW = CB'(H4NR_TICKS_TCYCE - H4NR_TICKS_PWEH - 1);
    localparam logic [CB-1:0] CNT_ONE = CB'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHIGH = 3'd2,
        ELOW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CB-1:0]   cnt_q, cnt_d;
    logic            nyb_q, nyb_d;        // 0 = high nybble, 1 = low nybble
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dat_q, dat_d;
    logic            rs_q, rs_d;
    logic            end_q, end_d;
    logic            e_q, e_d;
    logic            rw_q, rw_d;
    logic            oe_q, oe_d;
    logic            busy_q, busy_d;
    logic            cnt_last;

    assign cnt_last = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nyb_d   = nyb_q;
        shift_d = shift_q;
        dat_d   = dat_q;
        rs_d    = rs_q;
        end_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_strobe) begin
                    state_d = SETUP;
                    cnt_d   = LD_TAS;
                    nyb_d   = 1'b0;
                    rs_d    = rs_in;
                end
            end

            SETUP: begin
                if (cnt_last) begin
                    state_d = EHIGH;
                    cnt_d   = LD_PWEH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            EHIGH: begin
                if (cnt_last) begin
                    // Sample on the edge where E falls: the LCD's data is
                    // guaranteed valid for the whole tail of the pulse.
                    state_d = ELOW;
                    cnt_d   = LD_ELOW;
                    if (!nyb_q) begin
                        shift_d[7:4] = lcd_data_in;
                    end else begin
                        shift_d[3:0] = lcd_data_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ELOW: begin
                if (cnt_last) begin
                    if (!nyb_q) begin
                        state_d = SETUP;
                        cnt_d   = LD_TAS;
                        nyb_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DONE: begin
                // DAT_O and end_strobe are registered on the clock that ends
                // DONE, so the pulse coincides with the new byte.
                state_d = IDLE;
                cnt_d   = '0;
                dat_d   = shift_q;
                end_d   = 1'b1;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin-level outputs are decoded from the next state and registered so the
    // LCD sees glitch-free control lines aligned with the state register.
    always_comb begin
        e_d    = (state_d == EHIGH);
        rw_d   = (state_d == SETUP) || (state_d == EHIGH) || (state_d == ELOW);
        oe_d   = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nyb_q   <= 1'b0;
            shift_q <= 8'h00;
            dat_q   <= 8'h00;
            rs_q    <= 1'b0;
            end_q   <= 1'b0;
            e_q     <= 1'b0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nyb_q   <= nyb_d;
            shift_q <= shift_d;
            dat_q   <= dat_d;
            rs_q    <= rs_d;
            end_q   <= end_d;
            e_q     <= e_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign lcd_rs      = rs_q;
    assign lcd_rw      = rw_q;
    assign lcd_e       = e_q;
    assign lcd_data_oe = oe_q;
    assign DAT_O       = dat_q;
    assign busy        = busy_q;
    assign end_strobe  = end_q;

endmodule

// File: tb/tb_hd44780_nybble_reader.sv
// Bench for hd44780_nybble_reader: directed reads, expected bytes queued at
// issue time and popped by an independent end_strobe monitor.
// Runs with default timing parameters.

module tb_hd44780_nybble_reader;

    localparam int LAT = 103;   // accepting edge -> end_strobe, defaults
    localparam int PWEH = 22;

    logic       clk = 1'b0;
    logic       RST_I;
    logic       start_strobe;
    logic       rs_in;
    logic [3:0] lcd_data_in;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_data_oe, busy, end_strobe;
    logic [7:0] DAT_O;

    always #5 clk = ~clk;

    hd44780_nybble_reader dut (
        .CLK_I       (clk),
        .RST_I       (RST_I),
        .start_strobe(start_strobe),
        .rs_in       (rs_in),
        .lcd_data_in (lcd_data_in),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data_oe (lcd_data_oe),
        .DAT_O       (DAT_O),
        .busy        (busy),
        .end_strobe  (end_strobe)
    );

    // cyc equals the number of rising edges seen; read at negedges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       rs;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   rise_q[$];

    // ---------------- LCD pad model ----------------
    // Valid data is presented only in the cycle before each sample edge;
    // every other cycle carries the complement, so a mistimed sample shows.
    int         s0 = -100;
    int         s1 = -100;
    logic [3:0] n0 = 4'h0;
    logic [3:0] n1 = 4'h0;

    always @(negedge clk) begin
        if (cyc == s0)
            lcd_data_in = n0;
        else if (cyc == s1)
            lcd_data_in = n1;
        else if (cyc < (s0 + s1) / 2)
            lcd_data_in = ~n0;
        else
            lcd_data_in = ~n1;
    end

    // ---------------- end_strobe scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (end_strobe) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_end_strobe at cycle %0d: got 1 expected 0", cyc);
            end else begin
                e = sb.pop_front();
                chk("dat_o", {24'h0, DAT_O}, {24'h0, e.dat});
                chk("end_cycle", cyc, e.at);
                chk("lcd_rs_at_end", {31'h0, lcd_rs}, {31'h0, e.rs});
            end
        end
    end

    // ---------------- E pulse monitor ----------------
    logic e_prev  = 1'b0;
    bit   e_track = 1'b0;
    int   rise_at = 0;

    always @(negedge clk) begin
        if (lcd_e && !e_prev && rise_q.size() > 0) begin
            rise_at = cyc;
            e_track = 1'b1;
            chk("e_rise_cycle", cyc, rise_q.pop_front());
            chk("rw_at_rise", {31'h0, lcd_rw}, 32'd1);
            chk("oe_at_rise", {31'h0, lcd_data_oe}, 32'd0);
        end
        if (!lcd_e && e_prev && e_track) begin
            e_track = 1'b0;
            chk("e_high_width", cyc - rise_at, PWEH);
        end
        e_prev = lcd_e;
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; the following rising edge is the accepting edge.
    task automatic issue(input logic rs, input logic [3:0] hi, input logic [3:0] lo,
                         input logic [7:0] exp_byte, input bit expect_done,
                         input bit chk_e, output int acc);
        acc          = cyc + 1;
        start_strobe = 1'b1;
        rs_in        = rs;
        s0           = acc + 24;  // last EHIGH clock of nybble 0
        s1           = acc + 75;  // last EHIGH clock of nybble 1
        n0           = hi;
        n1           = lo;
        if (expect_done) sb.push_back('{exp_byte, rs, acc + LAT});
        if (chk_e) begin
            rise_q.push_back(acc + 3);
            rise_q.push_back(acc + 54);
        end
        @(negedge clk);
        start_strobe = 1'b0;
    endtask

    // Cycle-by-cycle shape of a read relative to its accepting edge.
    task automatic window(input int acc, input logic exp_rs, input bit noisy);
        int  e_err = 0, b_err = 0, rw_err = 0, oe_err = 0, rs_err = 0;
        bit  in_e, in_busy, in_rw;
        while (cyc < acc + LAT + 1) begin
            @(negedge clk);
            in_e    = (cyc >= acc + 3 && cyc <= acc + 24) || (cyc >= acc + 54 && cyc <= acc + 75);
            in_busy = (cyc >= acc && cyc <= acc + 102);
            in_rw   = (cyc >= acc && cyc <= acc + 101);
            if (lcd_e !== in_e) e_err++;
            if (busy !== in_busy) b_err++;
            if (lcd_rw !== in_rw) rw_err++;
            if (lcd_data_oe !== !in_busy) oe_err++;
            if (lcd_rs !== exp_rs) rs_err++;
            if (noisy) begin
                start_strobe = (cyc == acc + 39);
                rs_in        = cyc[2];
            end
        end
        start_strobe = 1'b0;
        chk("e_shape_errs", e_err, 0);
        chk("busy_shape_errs", b_err, 0);
        chk("rw_shape_errs", rw_err, 0);
        chk("oe_shape_errs", oe_err, 0);
        chk("rs_hold_errs", rs_err, 0);
    endtask

    initial begin
        int acc, acc2;
        RST_I        = 1'b1;
        start_strobe = 1'b0;
        rs_in        = 1'b0;

        // Reset held for two clocks.
        repeat (2) @(negedge clk);
        chk("rst_lcd_e", {31'h0, lcd_e}, 32'd0);
        chk("rst_lcd_rw", {31'h0, lcd_rw}, 32'd0);
        chk("rst_lcd_rs", {31'h0, lcd_rs}, 32'd0);
        chk("rst_oe", {31'h0, lcd_data_oe}, 32'd1);
        chk("rst_dat_o", {24'h0, DAT_O}, 32'h00);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_end", {31'h0, end_strobe}, 32'd0);
        RST_I = 1'b0;
        repeat (3) @(negedge clk);

        // Basic read, RS=0, with full E timing checks.
        issue(1'b0, 4'h8, 4'h3, 8'h83, 1'b1, 1'b1, acc);
        window(acc, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        // Ignored start at clock 40 and rs_in toggling mid-read.
        issue(1'b1, 4'hA, 4'h5, 8'hA5, 1'b1, 1'b1, acc);
        window(acc, 1'b1, 1'b1);
        rs_in = 1'b0;
        repeat (110) @(negedge clk);   // time for any stray second read to surface

        // Reset during the first EHIGH.
        issue(1'b1, 4'h7, 4'h1, 8'h00, 1'b0, 1'b0, acc);
        while (cyc < acc + 10) @(negedge clk);
        RST_I = 1'b1;
        @(negedge clk);
        RST_I = 1'b0;
        chk("mid_rst_lcd_e", {31'h0, lcd_e}, 32'd0);
        chk("mid_rst_rw", {31'h0, lcd_rw}, 32'd0);
        chk("mid_rst_oe", {31'h0, lcd_data_oe}, 32'd1);
        chk("mid_rst_busy", {31'h0, busy}, 32'd0);
        chk("mid_rst_dat_o", {24'h0, DAT_O}, 32'h00);
        repeat (LAT + 10) @(negedge clk);

        // Back-to-back: second start in the end_strobe (first IDLE) clock.
        issue(1'b1, 4'h6, 4'hC, 8'h6C, 1'b1, 1'b0, acc);
        while (cyc < acc + LAT) @(negedge clk);
        chk("b2b_end_seen", {31'h0, end_strobe}, 32'd1);
        chk("b2b_oe_gap", {31'h0, lcd_data_oe}, 32'd1);
        issue(1'b0, 4'h9, 4'hE, 8'h9E, 1'b1, 1'b0, acc2);
        chk("b2b_accept_edge", acc2, acc + 104);
        chk("b2b_oe_after", {31'h0, lcd_data_oe}, 32'd0);
        while (cyc < acc2 + LAT + 5) @(negedge clk);

        // Anything still queued was never delivered.
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_end_strobe: got none expected byte %0h at cycle %0d", e.dat, e.at);
        end
        while (rise_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL missing_e_rise: got none expected rise at cycle %0d", rise_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
